// File: rtl/crossbar_column.sv
// Egress-side column of the crossbar: round-robin packet arbitration among N requesters,
// one-hot grant held for the packet, and a single registered AXI-Stream output stage.
module crossbar_column #(
    parameter int P_CROSSBAR_N = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [P_CROSSBAR_N-1:0]    i_trans_req,
    output logic [P_CROSSBAR_N-1:0]    o_trans_grant,
    input  logic [P_CROSSBAR_N-1:0]    s_axis_rx_tvalid,
    input  logic [P_CROSSBAR_N*64-1:0] s_axis_rx_tdata,
    input  logic [P_CROSSBAR_N-1:0]    s_axis_rx_tlast,
    input  logic [P_CROSSBAR_N*8-1:0]  s_axis_rx_tkeep,
    input  logic [P_CROSSBAR_N-1:0]    s_axis_rx_tuser,
    output logic [P_CROSSBAR_N-1:0]    s_axis_rx_tready,
    output logic                       m_axis_tx_tvalid,
    output logic [63:0]                m_axis_tx_tdata,
    output logic                       m_axis_tx_tlast,
    output logic [7:0]                 m_axis_tx_tkeep,
    output logic                       m_axis_tx_tuser,
    input  logic                       m_axis_tx_tready
);

    localparam int N = P_CROSSBAR_N;
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q;
    logic [N-1:0]   grant_q;
    logic [W-1:0]   sel_idx_q;
    logic [W-1:0]   rr_ptr_q;
    logic           tvalid_q;
    logic [63:0]    tdata_q;
    logic           tlast_q;
    logic [7:0]     tkeep_q;
    logic           tuser_q;

    logic [W-1:0]   sel_d;
    logic [W-1:0]   cand;
    logic           found;
    logic           ready_int;
    logic           in_hs;
    logic           out_hs;

    logic [63:0]    rx_tdata_arr [N];
    logic [7:0]     rx_tkeep_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign rx_tdata_arr[gi]     = s_axis_rx_tdata[gi*64 +: 64];
            assign rx_tkeep_arr[gi]     = s_axis_rx_tkeep[gi*8 +: 8];
            assign s_axis_rx_tready[gi] = ready_int & grant_q[gi];
        end
    endgenerate

    // Search upward from the input after the last one served, so it gets lowest priority.
    always_comb begin
        sel_d = rr_ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(rr_ptr_q) + k) % N);
            if (!found && i_trans_req[cand]) begin
                found = 1'b1;
                sel_d = cand;
            end
        end
    end

    assign ready_int = (state_q == BUSY) && (!tvalid_q || m_axis_tx_tready);
    assign in_hs     = ready_int && s_axis_rx_tvalid[sel_idx_q];
    assign out_hs    = tvalid_q && m_axis_tx_tready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_idx_q <= '0;
            rr_ptr_q  <= W'(N - 1);
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            tkeep_q   <= '0;
            tuser_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q   <= {{(N-1){1'b0}}, 1'b1} << sel_d;
                        sel_idx_q <= sel_d;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_hs && s_axis_rx_tlast[sel_idx_q]) begin
                        rr_ptr_q <= sel_idx_q;
                        grant_q  <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A simultaneous in/out handshake keeps tvalid high and loads the new beat.
            if (in_hs) begin
                tvalid_q <= 1'b1;
                tdata_q  <= rx_tdata_arr[sel_idx_q];
                tkeep_q  <= rx_tkeep_arr[sel_idx_q];
                tlast_q  <= s_axis_rx_tlast[sel_idx_q];
                tuser_q  <= s_axis_rx_tuser[sel_idx_q];
            end else if (out_hs) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign o_trans_grant    = grant_q;
    assign m_axis_tx_tvalid = tvalid_q;
    assign m_axis_tx_tdata  = tdata_q;
    assign m_axis_tx_tlast  = tlast_q;
    assign m_axis_tx_tkeep  = tkeep_q;
    assign m_axis_tx_tuser  = tuser_q;

endmodule

// File: tb/tb_crossbar_column.sv
// Randomized bench for crossbar_column: a packet-level reference model predicts grants and
// the egress beat stream; a monitor pops the expected beats on each egress handshake.
module tb_crossbar_column;

    localparam int N    = 4;
    localparam int MAXB = 64;
    localparam int NPKT = 12;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic             i_clk;
    logic             i_rst;
    logic [N-1:0]     i_trans_req;
    logic [N-1:0]     o_trans_grant;
    logic [N-1:0]     s_axis_rx_tvalid;
    logic [N*64-1:0]  s_axis_rx_tdata;
    logic [N-1:0]     s_axis_rx_tlast;
    logic [N*8-1:0]   s_axis_rx_tkeep;
    logic [N-1:0]     s_axis_rx_tuser;
    logic [N-1:0]     s_axis_rx_tready;
    logic             m_axis_tx_tvalid;
    logic [63:0]      m_axis_tx_tdata;
    logic             m_axis_tx_tlast;
    logic [7:0]       m_axis_tx_tkeep;
    logic             m_axis_tx_tuser;
    logic             m_axis_tx_tready;

    crossbar_column #(.P_CROSSBAR_N(N)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_trans_req      (i_trans_req),
        .o_trans_grant    (o_trans_grant),
        .s_axis_rx_tvalid (s_axis_rx_tvalid),
        .s_axis_rx_tdata  (s_axis_rx_tdata),
        .s_axis_rx_tlast  (s_axis_rx_tlast),
        .s_axis_rx_tkeep  (s_axis_rx_tkeep),
        .s_axis_rx_tuser  (s_axis_rx_tuser),
        .s_axis_rx_tready (s_axis_rx_tready),
        .m_axis_tx_tvalid (m_axis_tx_tvalid),
        .m_axis_tx_tdata  (m_axis_tx_tdata),
        .m_axis_tx_tlast  (m_axis_tx_tlast),
        .m_axis_tx_tkeep  (m_axis_tx_tkeep),
        .m_axis_tx_tuser  (m_axis_tx_tuser),
        .m_axis_tx_tready (m_axis_tx_tready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int    checks = 0;
    int    errors = 0;
    beat_t mem [N][MAXB];
    int    nb [N];
    int    drv_ptr [N];
    int    mdl_ptr [N];
    beat_t exp_q [$];
    int    beats_seen = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet-granular round-robin plus a one-deep output register occupancy.
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_rdy;
    int           exp_sel;
    int           rr;
    bit           exp_full;
    bit           m_in_hs;
    bit           m_out_hs;
    bit           picked;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            exp_grant = '0;
            exp_full  = 1'b0;
            rr        = N - 1;
            exp_sel   = 0;
            exp_q.delete();
        end
        exp_rdy = (exp_grant != 0 && (!exp_full || m_axis_tx_tready)) ? exp_grant : '0;
        chk("grant", 80'(o_trans_grant), 80'(exp_grant));
        chk("s_tready", 80'(s_axis_rx_tready), 80'(exp_rdy));
        chk("m_tvalid", 80'(m_axis_tx_tvalid), 80'(exp_full));
        if (i_rst) begin
            m_in_hs  = (exp_rdy != 0) && ((exp_grant & s_axis_rx_tvalid) != 0);
            m_out_hs = exp_full && m_axis_tx_tready;
            if (exp_grant != 0) begin
                if (m_in_hs && s_axis_rx_tlast[exp_sel]) begin
                    rr        = exp_sel;
                    exp_grant = '0;
                end
            end else if (i_trans_req != 0) begin
                picked = 1'b0;
                for (int off = 1; off <= N; off++) begin
                    int c;
                    c = (rr + off) % N;
                    if (!picked && i_trans_req[c]) begin
                        picked    = 1'b1;
                        exp_sel   = c;
                        exp_grant = N'(1) << c;
                        while (mdl_ptr[c] < nb[c]) begin
                            exp_q.push_back(mem[c][mdl_ptr[c]]);
                            mdl_ptr[c]++;
                            if (mem[c][mdl_ptr[c]-1].last) break;
                        end
                    end
                end
            end
            exp_full = m_in_hs || (exp_full && !m_out_hs);
        end
    end

    // Monitor: compares each egress beat with the scoreboard and checks hold-under-backpressure.
    bit    prev_v;
    bit    prev_r;
    beat_t prev_b;
    beat_t cur_b;
    beat_t exp_b;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            cur_b = {m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast, m_axis_tx_tuser};
            if (prev_v && !prev_r) begin
                chk("hold_valid", 80'(m_axis_tx_tvalid), 80'(1));
                chk("hold_payload", 80'(cur_b), 80'(prev_b));
            end
            if (m_axis_tx_tvalid && m_axis_tx_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h expected=none t=%0t", cur_b, $time);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("beat", 80'(cur_b), 80'(exp_b));
                end
                beats_seen++;
            end
            prev_v = m_axis_tx_tvalid;
            prev_r = m_axis_tx_tready;
            prev_b = cur_b;
        end
    end

    task automatic drive(input int g, input int cyc);
        bit steady;
        steady = (cyc < 80);
        m_axis_tx_tready = steady ? 1'b1 : ($urandom % 10 < 6);
        for (int k = 0; k < N; k++) begin
            if (k == g && drv_ptr[k] < nb[k]) begin
                s_axis_rx_tvalid[k]        = steady ? 1'b1 : ($urandom % 10 < 7);
                s_axis_rx_tdata[k*64 +: 64] = mem[k][drv_ptr[k]].data;
                s_axis_rx_tkeep[k*8 +: 8]   = mem[k][drv_ptr[k]].keep;
                s_axis_rx_tlast[k]         = mem[k][drv_ptr[k]].last;
                s_axis_rx_tuser[k]         = mem[k][drv_ptr[k]].user;
                i_trans_req[k]             = steady ? 1'b1 : 1'($urandom % 2);
            end else begin
                s_axis_rx_tvalid[k]        = 1'($urandom % 2);
                s_axis_rx_tdata[k*64 +: 64] = {$urandom, $urandom};
                s_axis_rx_tkeep[k*8 +: 8]   = 8'($urandom);
                s_axis_rx_tlast[k]         = 1'($urandom % 2);
                s_axis_rx_tuser[k]         = 1'($urandom % 2);
                i_trans_req[k]             = (drv_ptr[k] < nb[k]) && (steady || ($urandom % 4 != 0));
            end
        end
    endtask

    int  cyc;
    int  g;
    int  gidx;
    bit  hs;
    bit  done;
    bit  rst_done;

    initial begin
        i_rst            = 1'b0;
        i_trans_req      = '0;
        s_axis_rx_tvalid = '0;
        s_axis_rx_tdata  = '0;
        s_axis_rx_tlast  = '0;
        s_axis_rx_tkeep  = '0;
        s_axis_rx_tuser  = '0;
        m_axis_tx_tready = 1'b0;
        for (int k = 0; k < N; k++) begin
            nb[k]      = 0;
            drv_ptr[k] = 0;
            mdl_ptr[k] = 0;
            for (int p = 0; p < NPKT; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    mem[k][nb[k]].data = {8'(k), 8'(p), 16'(b), 32'($urandom)};
                    mem[k][nb[k]].keep = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
                    mem[k][nb[k]].last = (b == len - 1);
                    mem[k][nb[k]].user = 1'($urandom % 2);
                    nb[k]++;
                end
            end
        end

        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_grant", 80'(o_trans_grant), 80'(0));
        chk("reset_tready", 80'(s_axis_rx_tready), 80'(0));
        chk("reset_mvalid", 80'(m_axis_tx_tvalid), 80'(0));
        chk("reset_mdata", 80'({m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast, m_axis_tx_tuser}), 80'(0));
        i_rst = 1'b1;

        cyc      = 0;
        done     = 1'b0;
        rst_done = 1'b0;
        while (!done && cyc < 4000) begin
            @(negedge i_clk);
            gidx = -1;
            for (int k = 0; k < N; k++) if (o_trans_grant[k]) gidx = k;
            hs = (gidx >= 0) && s_axis_rx_tvalid[gidx] && s_axis_rx_tready[gidx];
            @(posedge i_clk);
            #1;
            cyc++;
            if (hs) drv_ptr[gidx]++;
            g = -1;
            for (int k = 0; k < N; k++) if (o_trans_grant[k]) g = k;

            // Abort one packet part-way through with an asynchronous reset.
            if (!rst_done && cyc > 120 && g >= 0 && drv_ptr[g] > 0 && drv_ptr[g] < nb[g]
                && !mem[g][drv_ptr[g]-1].last) begin
                i_rst = 1'b0;
                #1;
                chk("abort_grant", 80'(o_trans_grant), 80'(0));
                chk("abort_tready", 80'(s_axis_rx_tready), 80'(0));
                chk("abort_mvalid", 80'(m_axis_tx_tvalid), 80'(0));
                while (drv_ptr[g] < nb[g]) begin
                    drv_ptr[g]++;
                    if (mem[g][drv_ptr[g]-1].last) break;
                end
                s_axis_rx_tvalid = '0;
                i_trans_req      = '0;
                repeat (2) @(posedge i_clk);
                #1;
                i_rst    = 1'b1;
                rst_done = 1'b1;
                g        = -1;
            end

            drive(g, cyc);
            done = (o_trans_grant == 0) && !m_axis_tx_tvalid && (exp_q.size() == 0);
            for (int k = 0; k < N; k++) if (drv_ptr[k] != nb[k]) done = 1'b0;
        end

        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=not_drained expected=drained cycles=%0d", cyc);
        end
        i_trans_req      = '0;
        s_axis_rx_tvalid = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_empty", 80'(exp_q.size()), 80'(0));
        chk("reset_injected", 80'(rst_done), 80'(1));
        chk("beats_seen_nonzero", 80'(beats_seen > 50), 80'(1));
        for (int k = 0; k < N; k++) chk("model_consumed", 80'(mdl_ptr[k]), 80'(nb[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
